// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions used by uart_rx and uart_tx: frame
//               geometry (8N1), receiver state encodings and small helper
//               functions for deriving bit-period timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame geometry: 8 data bits, 1 stop bit, no parity.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Receiver state encodings.
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    // Offset from the start-bit edge to the middle of the start bit.
    function automatic int half_period(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

    // Width of a counter able to hold 0..clks_per_bit.
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit + 1);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial input.
//               Both flops reset to 1 (line idle) so that reset never looks
//               like a start bit. Adds two clock cycles of latency.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset
//               i_rx      - raw serial line
//               o_rx_sync - synchronized serial line
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_rx_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rx_sync = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, idle-high line. The start bit
//               is qualified at its midpoint (HALF clocks after detection);
//               every following bit is sampled one bit period later. A low
//               stop bit reports a framing error and parks the receiver in
//               BREAK until the line returns high.
// Config      : UART_RX_SYNC_EN - when defined, rx passes through a
//               two-flop synchronizer (uart_rx_sync) before all sampling,
//               adding two cycles of latency. When undefined, rx is sampled
//               directly (same-clock on-chip loopback).
// Ports       : clk       - clock, rising edge active
//               rst       - asynchronous active-high reset
//               rx        - serial input
//               dout      - last received byte, held until next frame ends
//               rx_done   - one-cycle pulse, good frame, dout valid
//               frame_err - one-cycle pulse, stop bit sampled low
//               busy      - high while a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1   // legal range 1..1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------------
    localparam int c_HALF = half_period(CLKS_PER_BIT);
    localparam int c_CW   = cnt_width(CLKS_PER_BIT);
    localparam int c_IW   = $clog2(DATA_BITS);

    // The counter holds "edges elapsed since the last sample point minus one",
    // so a sample point is reached when it equals the period minus one.
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'((c_HALF > 0) ? (c_HALF - 1) : 0);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(DATA_BITS - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE   = c_IW'(1);

    // With a one- or two-clock bit period there is no start-bit midpoint to
    // wait for, so detection goes straight to data sampling.
    localparam logic [2:0] c_ST_AFTER_DETECT = (c_HALF > 0) ? c_ST_START : c_ST_DATA;

    // ------------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------------
    logic w_rx;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_rx      (rx),
        .o_rx_sync (w_rx)
    );
`else
    assign w_rx = rx;
`endif

    // ------------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [c_IW-1:0]      r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_done;
    logic                 r_ferr;
    logic                 r_busy;

    logic w_half_tick;
    logic w_bit_tick;

    assign w_half_tick = (r_cnt == c_HALF_LAST);
    assign w_bit_tick  = (r_cnt == c_BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle.
            r_done <= 1'b0;
            r_ferr <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!w_rx) begin
                        r_busy  <= 1'b1;
                        r_state <= c_ST_AFTER_DETECT;
                    end
                end

                c_ST_START: begin
                    if (w_half_tick) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            // Glitch shorter than half a bit: drop it silently.
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + c_IDX_ONE;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_STOP: begin
                    if (w_bit_tick) begin
                        // The byte is published even on a framing error so
                        // software can inspect what arrived.
                        r_cnt  <= '0;
                        r_dout <= r_shift;
                        r_busy <= 1'b0;
                        if (w_rx) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= c_ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_BREAK: begin
                    // A held-low line is not a stream of start bits; wait for
                    // the line to recover before listening again.
                    r_cnt <= '0;
                    if (w_rx) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign busy      = r_busy;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Two receivers run side by
//               side: one at 1 clock per bit (loopback timing) and one at 16
//               clocks per bit. Frames are driven bit by bit; a reference
//               model predicts the cycle and payload of every status pulse
//               from the frame timing rules, and recorded pulses are compared
//               against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif
    localparam int c_CPB_A  = 1;
    localparam int c_CPB_B  = 16;
    localparam int c_HALF_A = (c_CPB_A - 1) / 2;
    localparam int c_HALF_B = (c_CPB_B - 1) / 2;

    typedef struct {
        longint     c;
        logic [7:0] d;
        logic       done;
        logic       err;
    } ev_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic       rx_done_a, rx_done_b;
    logic       frame_err_a, frame_err_b;
    logic       busy_a, busy_b;

    longint     cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mdl_dout_a = 8'h00;
    logic [7:0] mdl_dout_b = 8'h00;
    ev_t        q_a[$], q_b[$];
    ev_t        exp_a[$], exp_b[$];

    uart_rx #(.CLKS_PER_BIT(c_CPB_A)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .dout(dout_a),
        .rx_done(rx_done_a), .frame_err(frame_err_a), .busy(busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(c_CPB_B)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .dout(dout_b),
        .rx_done(rx_done_b), .frame_err(frame_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which a status pulse is high.
    always @(negedge clk) begin
        if (rx_done_a || frame_err_a)
            q_a.push_back('{c: cyc, d: dout_a, done: rx_done_a, err: frame_err_a});
        if (rx_done_b || frame_err_b)
            q_b.push_back('{c: cyc, d: dout_b, done: rx_done_b, err: frame_err_b});
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Drives the first nbits of a frame (start, data LSB first, stop).
    // e returns the cycle on which the start bit was put on the line.
    task automatic send_frame(input int sel, input logic [7:0] b, input logic stop,
                              input int nbits, output longint e);
        logic [9:0] f;
        int         cpb;
        f   = {stop, b, 1'b0};
        cpb = (sel == 0) ? c_CPB_A : c_CPB_B;
        e   = cyc;
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, f[i]);
            tick(cpb);
        end
    endtask

    // Reference model: stop bit is sampled HALF + 9 bit periods after the
    // first edge that sees the start bit, which is one edge (plus any
    // synchronizer latency) after the start bit is driven.
    function automatic longint stop_cyc(input int sel, input longint e);
        if (sel == 0) return e + 1 + c_LAT + c_HALF_A + 9 * c_CPB_A;
        else          return e + 1 + c_LAT + c_HALF_B + 9 * c_CPB_B;
    endfunction

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({dout_a, rx_done_a, frame_err_a, busy_a} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_a: got dout=%h done=%b err=%b busy=%b, want all 0",
                     dout_a, rx_done_a, frame_err_a, busy_a);
        end
        n_vec++;
        if ({dout_b, rx_done_b, frame_err_b, busy_b} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_b: got dout=%h done=%b err=%b busy=%b, want all 0",
                     dout_b, rx_done_b, frame_err_b, busy_b);
        end
        tick(3);
        rst = 1'b0;
        mdl_dout_a = 8'h00;
        mdl_dout_b = 8'h00;
        tick(2);
        q_a.delete();
        q_b.delete();
    endtask

    task automatic test_loopback_b2b;
        longint e;
        send_frame(0, 8'hA5, 1'b1, 10, e);
        exp_a.push_back('{c: stop_cyc(0, e), d: 8'hA5, done: 1'b1, err: 1'b0});
        send_frame(0, 8'h3C, 1'b1, 10, e);
        exp_a.push_back('{c: stop_cyc(0, e), d: 8'h3C, done: 1'b1, err: 1'b0});
        mdl_dout_a = 8'h3C;
        tick(c_LAT + 4);
        n_vec++;
        if (q_a.size() != exp_a.size()) begin
            n_err++;
            $display("FAIL b2b_count: got %0d pulses, want %0d", q_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < q_a.size(); i++) begin
            n_vec++;
            if (q_a[i].c !== exp_a[i].c || q_a[i].d !== exp_a[i].d ||
                q_a[i].done !== exp_a[i].done || q_a[i].err !== exp_a[i].err) begin
                n_err++;
                $display("FAIL b2b_pulse%0d: got cyc=%0d dout=%h done=%b err=%b, want cyc=%0d dout=%h done=%b err=%b",
                         i, q_a[i].c, q_a[i].d, q_a[i].done, q_a[i].err,
                         exp_a[i].c, exp_a[i].d, exp_a[i].done, exp_a[i].err);
            end
        end
        q_a.delete();
        exp_a.delete();
    endtask

    task automatic test_sync_latency;
        longint e;
        send_frame(0, 8'h00, 1'b1, 10, e);
        tick(c_LAT + 4);
        mdl_dout_a = 8'h00;
        n_vec++;
        if (q_a.size() != 1) begin
            n_err++;
            $display("FAIL sync_count: got %0d pulses, want 1", q_a.size());
        end else if (q_a[0].c !== e + 10 + c_LAT || q_a[0].d !== 8'h00 || q_a[0].done !== 1'b1) begin
            n_err++;
            $display("FAIL sync_pulse: got cyc=%0d dout=%h done=%b, want cyc=%0d dout=00 done=1",
                     q_a[0].c, q_a[0].d, q_a[0].done, e + 10 + c_LAT);
        end
        q_a.delete();
    endtask

    task automatic test_random(input int sel, input int nframes);
        longint     e;
        logic [7:0] b;
        logic       bad;
        for (int k = 0; k < nframes; k++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(sel, b, !bad, 10, e);
            if (sel == 0) begin
                exp_a.push_back('{c: stop_cyc(0, e), d: b, done: !bad, err: bad});
                mdl_dout_a = b;
            end else begin
                exp_b.push_back('{c: stop_cyc(1, e), d: b, done: !bad, err: bad});
                mdl_dout_b = b;
            end
            set_rx(sel, 1'b1);
            tick(bad ? $urandom_range(1, 4) : $urandom_range(0, 3));
        end
        tick(c_LAT + 12);
        if (sel == 0) begin
            n_vec++;
            if (q_a.size() != exp_a.size()) begin
                n_err++;
                $display("FAIL rand_a_count: got %0d pulses, want %0d", q_a.size(), exp_a.size());
            end
            for (int i = 0; i < exp_a.size() && i < q_a.size(); i++) begin
                n_vec++;
                if (q_a[i].c !== exp_a[i].c || q_a[i].d !== exp_a[i].d ||
                    q_a[i].done !== exp_a[i].done || q_a[i].err !== exp_a[i].err) begin
                    n_err++;
                    $display("FAIL rand_a_pulse%0d: got cyc=%0d dout=%h done=%b err=%b, want cyc=%0d dout=%h done=%b err=%b",
                             i, q_a[i].c, q_a[i].d, q_a[i].done, q_a[i].err,
                             exp_a[i].c, exp_a[i].d, exp_a[i].done, exp_a[i].err);
                end
            end
            n_vec++;
            if (busy_a !== 1'b0 || dout_a !== mdl_dout_a) begin
                n_err++;
                $display("FAIL rand_a_final: got busy=%b dout=%h, want busy=0 dout=%h",
                         busy_a, dout_a, mdl_dout_a);
            end
            q_a.delete();
            exp_a.delete();
        end else begin
            n_vec++;
            if (q_b.size() != exp_b.size()) begin
                n_err++;
                $display("FAIL rand_b_count: got %0d pulses, want %0d", q_b.size(), exp_b.size());
            end
            for (int i = 0; i < exp_b.size() && i < q_b.size(); i++) begin
                n_vec++;
                if (q_b[i].c !== exp_b[i].c || q_b[i].d !== exp_b[i].d ||
                    q_b[i].done !== exp_b[i].done || q_b[i].err !== exp_b[i].err) begin
                    n_err++;
                    $display("FAIL rand_b_pulse%0d: got cyc=%0d dout=%h done=%b err=%b, want cyc=%0d dout=%h done=%b err=%b",
                             i, q_b[i].c, q_b[i].d, q_b[i].done, q_b[i].err,
                             exp_b[i].c, exp_b[i].d, exp_b[i].done, exp_b[i].err);
                end
            end
            n_vec++;
            if (busy_b !== 1'b0 || dout_b !== mdl_dout_b) begin
                n_err++;
                $display("FAIL rand_b_final: got busy=%b dout=%h, want busy=0 dout=%h",
                         busy_b, dout_b, mdl_dout_b);
            end
            q_b.delete();
            exp_b.delete();
        end
    endtask

    task automatic test_frame_err;
        longint e, e2;
        int     busy_cnt;
        send_frame(1, 8'h55, 1'b0, 10, e);
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (busy_b) busy_cnt++;
        end
        n_vec++;
        if (busy_cnt != 0) begin
            n_err++;
            $display("FAIL ferr_break_busy: got busy high %0d cycles while line low, want 0", busy_cnt);
        end
        n_vec++;
        if (q_b.size() != 1) begin
            n_err++;
            $display("FAIL ferr_count: got %0d pulses, want 1", q_b.size());
        end else if (q_b[0].c !== stop_cyc(1, e) || q_b[0].d !== 8'h55 ||
                     q_b[0].err !== 1'b1 || q_b[0].done !== 1'b0) begin
            n_err++;
            $display("FAIL ferr_pulse: got cyc=%0d dout=%h done=%b err=%b, want cyc=%0d dout=55 done=0 err=1",
                     q_b[0].c, q_b[0].d, q_b[0].done, q_b[0].err, stop_cyc(1, e));
        end
        q_b.delete();
        set_rx(1, 1'b1);
        tick(3);
        send_frame(1, 8'h9A, 1'b1, 10, e2);
        tick(c_LAT + 4);
        mdl_dout_b = 8'h9A;
        n_vec++;
        if (q_b.size() != 1 || q_b[0].c !== stop_cyc(1, e2) || q_b[0].d !== 8'h9A || q_b[0].done !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_recover: got %0d pulses dout=%h, want 1 pulse at cyc=%0d dout=9a",
                     q_b.size(), dout_b, stop_cyc(1, e2));
        end
        q_b.delete();
    endtask

    task automatic test_false_start;
        int busy_cnt;
        busy_cnt = 0;
        set_rx(1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 3) set_rx(1, 1'b1);
            if (busy_b) busy_cnt++;
        end
        n_vec++;
        if (busy_cnt < 1 || busy_cnt > c_HALF_B + 1) begin
            n_err++;
            $display("FAIL false_start_busy: got busy high %0d cycles, want 1..%0d", busy_cnt, c_HALF_B + 1);
        end
        n_vec++;
        if (q_b.size() != 0 || busy_b !== 1'b0 || dout_b !== mdl_dout_b) begin
            n_err++;
            $display("FAIL false_start_quiet: got %0d pulses busy=%b dout=%h, want 0 pulses busy=0 dout=%h",
                     q_b.size(), busy_b, dout_b, mdl_dout_b);
        end
        q_b.delete();
    endtask

    task automatic test_reset_midframe;
        longint e;
        send_frame(0, 8'hFF, 1'b1, 6, e);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({dout_a, rx_done_a, frame_err_a, busy_a} !== 11'd0) begin
            n_err++;
            $display("FAIL midframe_reset: got dout=%h done=%b err=%b busy=%b, want all 0",
                     dout_a, rx_done_a, frame_err_a, busy_a);
        end
        mdl_dout_a = 8'h00;
        mdl_dout_b = 8'h00;
        set_rx(0, 1'b1);
        tick(2);
        rst = 1'b0;
        tick(2);
        send_frame(0, 8'h81, 1'b1, 10, e);
        tick(c_LAT + 4);
        mdl_dout_a = 8'h81;
        n_vec++;
        if (q_a.size() != 1) begin
            n_err++;
            $display("FAIL midframe_count: got %0d pulses, want 1", q_a.size());
        end else if (q_a[0].c !== stop_cyc(0, e) || q_a[0].d !== 8'h81 || q_a[0].done !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_next: got cyc=%0d dout=%h done=%b, want cyc=%0d dout=81 done=1",
                     q_a[0].c, q_a[0].d, q_a[0].done, stop_cyc(0, e));
        end
        q_a.delete();
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_loopback_b2b();
        test_sync_latency();
        test_random(0, 24);
        test_random(1, 8);
        test_frame_err();
        test_false_start();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by 2 ms, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_rx
`default_nettype wire
